// File: rtl/manchester_pkg.sv
// manchester_pkg: state encoding and line conventions shared by the Manchester encoder and decoder.
package manchester_pkg;
  typedef enum logic [1:0] {IDLE, FIRST_HALF, SECOND_HALF} mch_state_t;
  localparam int CONV_IEEE = 0;
  localparam int CONV_THOMAS = 1;
endpackage

// File: rtl/manchester_half_bit_tick.sv
// manchester_half_bit_tick: half-bit timer, ticks on the last cycle of each half-bit while enabled.
module manchester_half_bit_tick #(
  parameter int HALF_BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick,
  output logic o_tick_next
);
  localparam int CW = HALF_BIT_CYCLES > 1 ? $clog2(HALF_BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_BIT_CYCLES - 1);
  localparam logic [CW-1:0] PRE = CW'(HALF_BIT_CYCLES - 2);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= (rst || !i_en || o_tick) ? '0 : r_cnt + CW'(1);
  always_comb begin
    o_tick = i_en && r_cnt == LAST;
    // lets the encoder register frame_done one cycle ahead of the final tick
    o_tick_next = (HALF_BIT_CYCLES == 1) || (i_en && r_cnt == PRE);
  end
endmodule

// File: rtl/manchester_encoder.sv
// manchester_encoder: valid/ready word input, Manchester-encoded serial output with gapless back-to-back frames.
module manchester_encoder
  import manchester_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int HALF_BIT_CYCLES = 4,
  parameter int MSB_FIRST = 1,
  parameter int CONVENTION = CONV_IEEE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              tx_active,
  output logic              frame_done
);
  localparam int BW = $clog2(DATA_W);
  if (DATA_W < 2 || HALF_BIT_CYCLES < 1) begin : g_bad_params
    $fatal(1, "manchester_encoder: DATA_W must be >= 2 and HALF_BIT_CYCLES >= 1");
  end
  mch_state_t r_state, w_nstate;
  logic [DATA_W-1:0] r_shift, w_nshift;
  logic [BW-1:0] r_bit_idx, w_nidx;
  logic w_tick, w_tick_next, w_hs, w_adv, w_last, w_bit;
  manchester_half_bit_tick #(.HALF_BIT_CYCLES(HALF_BIT_CYCLES)) u_tick (
    .clk        (clk),
    .rst        (rst),
    .i_en       (r_state != IDLE),
    .o_tick     (w_tick),
    .o_tick_next(w_tick_next)
  );
  always_comb begin
    w_last = r_state == SECOND_HALF && w_tick && r_bit_idx == '0;
    w_adv = r_state == SECOND_HALF && w_tick && r_bit_idx != '0;
    in_ready = !rst && (r_state == IDLE || w_last);
    w_hs = in_valid && in_ready;
    w_nstate = w_hs ? FIRST_HALF :
               (r_state == FIRST_HALF && w_tick) ? SECOND_HALF :
               w_adv ? FIRST_HALF :
               w_last ? IDLE : r_state;
    w_nshift = w_hs ? in_data :
               !w_adv ? r_shift :
               MSB_FIRST != 0 ? {r_shift[DATA_W-2:0], 1'b0} : {1'b0, r_shift[DATA_W-1:1]};
    w_nidx = w_hs ? BW'(DATA_W - 1) : w_adv ? r_bit_idx - BW'(1) : r_bit_idx;
    w_bit = MSB_FIRST != 0 ? w_nshift[DATA_W-1] : w_nshift[0];
  end
  // outputs are registered from next-state values so the line changes together with the state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit_idx <= '0;
      tx_out <= 1'b0;
      tx_active <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_shift <= w_nshift;
      r_bit_idx <= w_nidx;
      tx_active <= w_nstate != IDLE;
      tx_out <= w_nstate != IDLE && (w_bit ^ (w_nstate == FIRST_HALF) ^ (CONVENTION == CONV_THOMAS));
      frame_done <= w_nstate == SECOND_HALF && w_nidx == '0 && w_tick_next;
    end
  end
endmodule
